// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flush and optional
// multi-cycle execute stall (enabled by defining HAZARD_MC_STALL_EN).
module hazard_ctrl #(
  parameter int unsigned MC_CYCLES = 4,
  parameter int unsigned RA_W      = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_uses_rs2,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_mc_start,
  input  logic            branch_taken,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            ctrl_sel,
  output logic            ex_hold,
  output logic [15:0]     stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   load_use;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

`ifdef HAZARD_MC_STALL_EN
  localparam logic [3:0] MC_LOAD = 4'(MC_CYCLES - 1);
  logic [3:0] mc_cnt, mc_cnt_nxt;
`else
  localparam int unsigned unused_mc_cycles = MC_CYCLES;
  logic unused_mc_start;
  assign unused_mc_start = ex_mc_start;
`endif

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    ctrl_sel   = 1'b0;
    ex_hold    = 1'b0;
    state_nxt  = state;
`ifdef HAZARD_MC_STALL_EN
    mc_cnt_nxt = mc_cnt;
`endif
    if (!rst_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      state_nxt  = RUN;
`ifdef HAZARD_MC_STALL_EN
      mc_cnt_nxt = '0;
`endif
    end else begin
      unique case (state)
        RUN: begin
          if (branch_taken) begin
            ifid_flush = 1'b1;
            ctrl_sel   = 1'b1;
            state_nxt  = FLUSH;
`ifdef HAZARD_MC_STALL_EN
          end else if (ex_mc_start) begin
            mc_cnt_nxt = MC_LOAD;
            state_nxt  = MC_STALL;
`endif
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctrl_sel   = 1'b1;
          end
        end
`ifdef HAZARD_MC_STALL_EN
        MC_STALL: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          ex_hold    = 1'b1;
          mc_cnt_nxt = mc_cnt - 4'd1;
          if (mc_cnt == 4'd1) state_nxt = RUN;
        end
`endif
        FLUSH: begin
          ifid_flush = 1'b1;
          ctrl_sel   = 1'b1;
          state_nxt  = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state <= state_nxt;
`ifdef HAZARD_MC_STALL_EN
    mc_cnt <= mc_cnt_nxt;
`endif
    if (!rst_n)
      stall_count <= '0;
    else if (!pc_write && (stall_count != '1))
      stall_count <= stall_count + 16'd1;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MC_CYCLES, default 4, execute-stage occupancy of a multi-cycle op in cycles; legal range 2..15.
REQ-002 Parameter RA_W, default 5, register-address width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 id_rs1, id_rs2  in  RA_W  source registers of the instruction in ID.
REQ-006 id_uses_rs2  in  1  1 = ID instruction reads rs2.
REQ-007 ex_mem_read  in  1  EX instruction is a load.
REQ-008 ex_rd  in  RA_W  EX destination register.
REQ-009 ex_mc_start  in  1  EX instruction is a multi-cycle op entering EX this cycle.
REQ-010 branch_taken  in  1  EX resolved a taken branch/jump this cycle.
REQ-011 pc_write  out  1  1 = PC register loads.
REQ-012 ifid_write  out  1  1 = IF/ID register loads.
REQ-013 ifid_flush  out  1  1 = IF/ID register loads a NOP.
REQ-014 ctrl_sel  out  1  select of the downstream 1-bit control MUXes: 0 = decoded control, 1 = bubble (all-zero control).
REQ-015 ex_hold  out  1  1 = ID/EX register holds.
REQ-016 stall_count  out  16  count of cycles with pc_write=0.

Function
REQ-017 The FSM SHALL have states RUN, MC_STALL, FLUSH; outputs are combinational from state and inputs.
REQ-018 Load-use hazard SHALL be: ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
REQ-019 In RUN with no event: pc_write=1, ifid_write=1, ifid_flush=0, ctrl_sel=0, ex_hold=0; next state RUN.
REQ-020 In RUN, branch_taken=1 SHALL give same-cycle ifid_flush=1, ctrl_sel=1, pc_write=1, ifid_write=1; next state FLUSH.
REQ-021 FLUSH SHALL last exactly one cycle: ifid_flush=1, ctrl_sel=1, pc_write=1, ifid_write=1; next state RUN; all inputs ignored.
REQ-022 In RUN, ex_mc_start=1 (no branch_taken) SHALL load counter with MC_CYCLES-1 and enter MC_STALL; outputs this cycle are RUN defaults.
REQ-023 In MC_STALL: pc_write=0, ifid_write=0, ctrl_sel=0, ex_hold=1; counter decrements each cycle; when counter==1, next state RUN; total MC_STALL cycles = MC_CYCLES-1.
REQ-024 In MC_STALL, branch_taken, ex_mc_start and load-use SHALL be ignored.
REQ-025 In RUN, load-use hazard (no branch_taken, no ex_mc_start) SHALL give same-cycle pc_write=0, ifid_write=0, ctrl_sel=1; next state RUN (one bubble).
REQ-026 Priority in RUN: branch_taken > ex_mc_start > load-use.
REQ-027 stall_count SHALL increment each cycle pc_write=0 and saturate at 16'hFFFF.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force state RUN, counter 0, stall_count 0, regardless of current state (including mid-MC_STALL or FLUSH).
REQ-029 During reset cycle outputs SHALL equal RUN defaults except pc_write=0 and ifid_write=0.

Configuration
REQ-030 Macro HAZARD_MC_STALL_EN defined: multi-cycle support per REQ-022..024.
REQ-031 Macro absent: ex_mc_start ignored, MC_STALL and counter not built, ex_hold tied 0; all other behaviour unchanged.

Verification
REQ-032 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 -> one cycle pc_write=0, ifid_write=0, ctrl_sel=1, then RUN defaults; stall_count=1.
REQ-033 ex_rd=0 with ex_mem_read=1, id_rs1=0 -> no stall.
REQ-034 branch_taken pulse -> two consecutive cycles ifid_flush=1, ctrl_sel=1; load-use asserted same cycle ignored.
REQ-035 MC_CYCLES=4, ex_mc_start pulse -> ex_hold=1 and pc_write=0 for exactly 3 cycles; stall_count=3; branch_taken during stall ignored.
REQ-036 rst_n=0 during 2nd MC_STALL cycle -> next cycle RUN defaults, stall_count=0.
REQ-037 Build without HAZARD_MC_STALL_EN: ex_mc_start pulse -> no stall, ex_hold=0 throughout.
